bam_seq: RTL and testbench
==========================

Name: bam_seq

Overview:
- Instruction sequencer for the `bam` register-bank/ALU block.
- Accepts 32-bit instructions over a valid/ready handshake. Each one is either an R-type ALU operation or an immediate data write.
- Decodes the instruction and drives every `bam` control port. Holds ALU controls stable for a settle window, then issues a one-cycle write strobe.
- Reports result, zero flag, done/error pulses and a retired-instruction count to the upstream controller.

Parameters:
- SETTLE, 1, cycles the ALU controls are held before the write strobe (minimum 1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- instValid  in  1  upstream has an instruction.
- instData  in  32  instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct, [15:0] imm.
- instReady  out  1  sequencer can accept an instruction.
- bamRA1  out  5  bank read address A (rs).
- bamRA2  out  5  bank read address B (rt).
- bamDirB  out  5  ALU-result write address (rd).
- bamSel  out  4  ALU select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- bamRegWrite  out  1  ALU-result write strobe.
- bamwr  out  1  direct data-write strobe.
- bamDir  out  5  direct data-write address.
- bamDi  out  32  direct data-write value.
- bamDoubt  in  32  ALU result from `bam` (combinational from RA1/RA2/Sel).
- bamZf  in  1  ALU zero flag from `bam`.
- seqDone  out  1  one-cycle pulse when an instruction retires.
- seqErr  out  1  one-cycle pulse on an illegal instruction.
- seqResult  out  32  last ALU result or written immediate.
- seqZero  out  1  zero flag of the last ALU op.
- seqCount  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - State goes to IDLE.
  - All outputs go to 0, except instReady, which is 1.
  - Any in-flight instruction is discarded with no strobe.
- Handshake:
  - An instruction is accepted on a rising edge where instValid and instReady are both 1. instData is captured into a holding register.
  - instReady is 1 only in IDLE, so there are no back-to-back accepts.
  - instValid while busy is ignored; upstream must hold it.
- FSM states: IDLE, DECODE, EXEC, WB, MEMW, ERR.
- IDLE → DECODE on accept.
- DECODE (1 cycle): classify the instruction.
  - op=000000 with funct in {100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 101010 SLT} → EXEC.
  - op=101011 → MEMW.
  - Anything else → ERR.
- EXEC:
  - bamRA1=rs, bamRA2=rt, bamDirB=rd, bamSel=decoded code.
  - Settle counter loads SETTLE−1 and decrements; at 0 → WB.
- WB (1 cycle):
  - Same addresses and select as EXEC, plus bamRegWrite=1.
  - Capture seqResult←bamDoubt and seqZero←bamZf.
  - seqDone=1; seqCount increments → IDLE.
  - If rd=0: bamRegWrite stays 0 (r0 protected), but result/zero/done/count still update.
- MEMW (1 cycle):
  - bamwr=1, bamDir=rt, bamDi=zero-extended imm.
  - seqResult←bamDi; seqZero unchanged.
  - seqDone=1; seqCount increments → IDLE.
- ERR (1 cycle):
  - seqErr=1; no strobes; seqCount unchanged → IDLE.
- Timing and output rules:
  - Latency from accept edge to seqDone: 2+SETTLE cycles for ALU ops, 2 cycles for writes/errors.
  - bamRA1/RA2/DirB/Sel hold their last values outside EXEC/WB (no glitching).
  - bamRegWrite and bamwr are never both 1.
  - seqCount wraps from 2^CNT_W−1 to 0 silently.
  - seqDone and seqErr are never both 1.
  - rst_n asserted during EXEC or WB: the strobe drops in the same cycle and the write must not occur.

Test Plan:
1. Reset then ADD rs=23, rt=12, rd=13 (bank r23=10, r12=5):
   - bamSel=0010 for SETTLE cycles, then a single-cycle bamRegWrite with bamDirB=13.
   - seqResult=15, seqZero=0, seqDone at accept+3, seqCount=1.
2. SUB rs=15, rt=7, rd=14 with r15=r7=42:
   - bamSel=0110, seqResult=0, seqZero=1, bank r14=0.
3. op=101011, rt=5, imm=456:
   - bamwr pulses one cycle with bamDir=5, bamDi=456; bamRegWrite stays 0.
   - seqResult=456, seqDone at accept+2.
4. Illegal funct 000111, then AND rs=1, rt=7, rd=1:
   - First: seqErr one cycle, no strobes, seqCount unchanged.
   - Second: executes normally, seqCount +1.
5. ADD with rd=0:
   - No bamRegWrite; seqDone=1, seqCount +1.
   - instValid held during busy → only one accept per IDLE visit.
6. Assert rst_n low mid-EXEC:
   - All outputs 0 immediately, instReady=1, no write to the bank.
   - CNT_W=2 with 5 retired instructions → seqCount=1.

Source files
------------

// File: rtl/bam_seq.sv
// Instruction sequencer for the bam register-bank/ALU block: accepts R-type ALU ops and
// immediate writes over valid/ready, drives bam controls, and reports retirement status.
module bam_seq #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instValid,
  input  logic [31:0]      instData,
  output logic             instReady,
  output logic [4:0]       bamRA1,
  output logic [4:0]       bamRA2,
  output logic [4:0]       bamDirB,
  output logic [3:0]       bamSel,
  output logic             bamRegWrite,
  output logic             bamwr,
  output logic [4:0]       bamDir,
  output logic [31:0]      bamDi,
  input  logic [31:0]      bamDoubt,
  input  logic             bamZf,
  output logic             seqDone,
  output logic             seqErr,
  output logic [31:0]      seqResult,
  output logic             seqZero,
  output logic [CNT_W-1:0] seqCount
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StWb, StMemw, StErr} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [5:0]      op_q;
  logic [4:0]      rs_q, rt_q;
  logic [15:0]     imm_q;
  logic [4:0]      ra1_q, ra2_q, dirb_q, dir_q;
  logic [3:0]      sel_q;
  logic [31:0]     di_q, result_q;
  logic            zero_q;
  logic [CNT_W-1:0] count_q;

  logic       accept;
  logic       is_alu, is_memw;
  logic [3:0] dec_sel;
  logic [5:0] funct;

  // rd and funct overlap the immediate field, so only imm_q is stored.
  assign funct   = imm_q[5:0];
  assign accept  = (state_q == StIdle) && instValid;
  assign is_memw = (op_q == 6'b101011);

  always_comb begin
    is_alu  = 1'b0;
    dec_sel = 4'b0000;
    if (op_q == 6'b000000) begin
      case (funct)
        6'b100100: begin is_alu = 1'b1; dec_sel = 4'b0000; end
        6'b100101: begin is_alu = 1'b1; dec_sel = 4'b0001; end
        6'b100000: begin is_alu = 1'b1; dec_sel = 4'b0010; end
        6'b100010: begin is_alu = 1'b1; dec_sel = 4'b0110; end
        6'b101010: begin is_alu = 1'b1; dec_sel = 4'b0111; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: begin
        if (is_alu) begin
          state_d  = StExec;
          settle_d = SW'(SETTLE - 1);
        end else if (is_memw) begin
          state_d = StMemw;
        end else begin
          state_d = StErr;
        end
      end
      StExec: begin
        if (settle_q == '0) state_d = StWb;
        else                settle_d = settle_q - 1'b1;
      end
      StWb, StMemw, StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    instReady   = 1'b0;
    bamRegWrite = 1'b0;
    bamwr       = 1'b0;
    seqDone     = 1'b0;
    seqErr      = 1'b0;
    unique case (state_q)
      StIdle: instReady = 1'b1;
      StWb: begin
        bamRegWrite = (dirb_q != 5'd0);  // r0 is never written
        seqDone     = 1'b1;
      end
      StMemw: begin
        bamwr   = 1'b1;
        seqDone = 1'b1;
      end
      StErr:   seqErr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      dirb_q   <= '0;
      sel_q    <= '0;
      dir_q    <= '0;
      di_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= instData[31:26];
        rs_q  <= instData[25:21];
        rt_q  <= instData[20:16];
        imm_q <= instData[15:0];
      end
      // Bank controls change only on entry to EXEC or MEMW, so they hold elsewhere.
      if (state_q == StDecode && is_alu) begin
        ra1_q  <= rs_q;
        ra2_q  <= rt_q;
        dirb_q <= imm_q[15:11];
        sel_q  <= dec_sel;
      end
      if (state_q == StDecode && !is_alu && is_memw) begin
        dir_q <= rt_q;
        di_q  <= {16'h0000, imm_q};
      end
      if (state_q == StWb) begin
        result_q <= bamDoubt;
        zero_q   <= bamZf;
        count_q  <= count_q + 1'b1;
      end
      if (state_q == StMemw) begin
        result_q <= di_q;
        count_q  <= count_q + 1'b1;
      end
    end
  end

  assign bamRA1    = ra1_q;
  assign bamRA2    = ra2_q;
  assign bamDirB   = dirb_q;
  assign bamSel    = sel_q;
  assign bamDir    = dir_q;
  assign bamDi     = di_q;
  assign seqResult = result_q;
  assign seqZero   = zero_q;
  assign seqCount  = count_q;

endmodule

// File: tb/tb_bam_seq.sv
// Bench for bam_seq: behavioural bank/ALU model drives the DUT, and a reference model of the
// instruction semantics predicts results, strobes, latencies and counts.
module tb_bam_seq;
  localparam int unsigned SETTLE = 3;
  localparam logic [5:0] FUNCTS [5] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
  localparam logic [3:0] SELS   [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        instValid = 1'b0;
  logic [31:0] instData = '0;
  logic        instReady, bamRegWrite, bamwr, bamZf, seqDone, seqErr, seqZero;
  logic [4:0]  bamRA1, bamRA2, bamDirB, bamDir;
  logic [3:0]  bamSel;
  logic [31:0] bamDi, bamDoubt, seqResult;
  logic [15:0] seqCount;

  logic        w2_instReady, w2_bamRegWrite, w2_bamwr, w2_seqDone, w2_seqErr, w2_seqZero;
  logic [4:0]  w2_bamRA1, w2_bamRA2, w2_bamDirB, w2_bamDir;
  logic [3:0]  w2_bamSel;
  logic [31:0] w2_bamDi, w2_seqResult;
  logic [1:0]  w2_seqCount;

  bam_seq #(.SETTLE(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instValid(instValid), .instData(instData),
    .instReady(instReady), .bamRA1(bamRA1), .bamRA2(bamRA2), .bamDirB(bamDirB),
    .bamSel(bamSel), .bamRegWrite(bamRegWrite), .bamwr(bamwr), .bamDir(bamDir),
    .bamDi(bamDi), .bamDoubt(bamDoubt), .bamZf(bamZf), .seqDone(seqDone), .seqErr(seqErr),
    .seqResult(seqResult), .seqZero(seqZero), .seqCount(seqCount)
  );

  bam_seq #(.SETTLE(SETTLE), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instValid(instValid), .instData(instData),
    .instReady(w2_instReady), .bamRA1(w2_bamRA1), .bamRA2(w2_bamRA2), .bamDirB(w2_bamDirB),
    .bamSel(w2_bamSel), .bamRegWrite(w2_bamRegWrite), .bamwr(w2_bamwr), .bamDir(w2_bamDir),
    .bamDi(w2_bamDi), .bamDoubt(bamDoubt), .bamZf(bamZf), .seqDone(w2_seqDone),
    .seqErr(w2_seqErr), .seqResult(w2_seqResult), .seqZero(w2_seqZero),
    .seqCount(w2_seqCount)
  );

  // Behavioural bam block: register bank plus combinational ALU.
  logic [31:0] bank [32];
  logic        do_set = 1'b0;
  logic [4:0]  set_idx = '0;
  logic [31:0] set_val = '0;

  always @(posedge clk) begin
    if (do_set) bank[set_idx] <= set_val;
    else begin
      if (bamRegWrite) bank[bamDirB] <= bamDoubt;
      if (bamwr)       bank[bamDir]  <= bamDi;
    end
  end

  always_comb begin
    bamDoubt = '0;
    case (bamSel)
      4'b0000: bamDoubt = bank[bamRA1] & bank[bamRA2];
      4'b0001: bamDoubt = bank[bamRA1] | bank[bamRA2];
      4'b0010: bamDoubt = bank[bamRA1] + bank[bamRA2];
      4'b0110: bamDoubt = bank[bamRA1] - bank[bamRA2];
      4'b0111: bamDoubt = ($signed(bank[bamRA1]) < $signed(bank[bamRA2])) ? 32'd1 : 32'd0;
      default: bamDoubt = '0;
    endcase
    bamZf = (bamDoubt == 32'd0);
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_bank [32];
  int unsigned ref_count;
  logic [31:0] ref_result;
  logic        ref_zero;

  int          obs_done, obs_err, obs_rw, obs_wr, obs_both, obs_ready_busy;
  logic [4:0]  obs_rw_addr, obs_wr_addr, obs_ra1, obs_ra2;
  logic [31:0] obs_wr_data;
  logic [3:0]  obs_sel_first, obs_sel_last;

  logic [4:0]  cur_rd;
  int          cur_kind;
  logic [3:0]  cur_sel;

  function automatic logic [123:0] out_vec();
    return {bamRA1, bamRA2, bamDirB, bamSel, bamRegWrite, bamwr, bamDir, bamDi, seqDone,
            seqErr, seqResult, seqZero, seqCount};
  endfunction

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
    set_idx = idx; set_val = val; do_set = 1'b1;
    @(posedge clk); #1;
    do_set = 1'b0;
    ref_bank[idx] = val;
  endtask

  // Reference semantics: kind 0 = ALU, 1 = immediate write, 2 = illegal.
  task automatic model(input logic [31:0] inst, output int kind, output logic [3:0] sel);
    logic [31:0] a, b, r;
    kind = 2; sel = 4'b0000;
    a = ref_bank[inst[25:21]];
    b = ref_bank[inst[20:16]];
    r = '0;
    if (inst[31:26] == 6'b101011) kind = 1;
    else if (inst[31:26] == 6'b000000)
      for (int i = 0; i < 5; i++) if (inst[5:0] == FUNCTS[i]) begin kind = 0; sel = SELS[i]; end
    if (kind == 0) begin
      case (inst[5:0])
        6'b100100: r = a & b;
        6'b100101: r = a | b;
        6'b100000: r = a + b;
        6'b100010: r = a - b;
        default:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      if (inst[15:11] != 5'd0) ref_bank[inst[15:11]] = r;
      ref_result = r; ref_zero = (r == 32'd0); ref_count++;
    end else if (kind == 1) begin
      ref_bank[inst[20:16]] = {16'h0, inst[15:0]};
      ref_result = {16'h0, inst[15:0]}; ref_count++;
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] x;
    int c;
    bit legal;
    x = $urandom;
    c = $urandom_range(0, 5);
    if (c <= 2) begin
      x[31:26] = 6'b000000;
      x[5:0] = FUNCTS[$urandom_range(0, 4)];
    end else if (c == 3) begin
      x[31:26] = 6'b101011;
    end else if (c == 4) begin
      x[31:26] = 6'b000000;
      do begin
        x[5:0] = 6'($urandom);
        legal = 1'b0;
        for (int i = 0; i < 5; i++) if (x[5:0] == FUNCTS[i]) legal = 1'b1;
      end while (legal);
    end else begin
      while (x[31:26] == 6'b000000 || x[31:26] == 6'b101011) x[31:26] = 6'($urandom);
    end
    return x;
  endfunction

  task automatic start(input logic [31:0] inst, input bit hold);
    int guard = 0;
    @(negedge clk);
    while (!instReady && guard < 50) begin @(negedge clk); guard++; end
    instValid = 1'b1; instData = inst;
    @(posedge clk); #1;
    if (!hold) instValid = 1'b0;
  endtask

  // Drives one instruction and records what the DUT did until it retires or errors.
  task automatic issue(input logic [31:0] inst, input bit hold);
    obs_done = -1; obs_err = -1; obs_rw = 0; obs_wr = 0; obs_both = 0; obs_ready_busy = 0;
    obs_rw_addr = '0; obs_wr_addr = '0; obs_wr_data = '0; obs_sel_first = '0;
    obs_sel_last = '0; obs_ra1 = '0; obs_ra2 = '0;
    model(inst, cur_kind, cur_sel);
    cur_rd = inst[15:11];
    start(inst, hold);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (instReady) obs_ready_busy++;
      if (bamRegWrite) begin obs_rw++; obs_rw_addr = bamDirB; end
      if (bamwr) begin obs_wr++; obs_wr_addr = bamDir; obs_wr_data = bamDi; end
      if ((bamRegWrite && bamwr) || (seqDone && seqErr)) obs_both++;
      if (k == 2) obs_sel_first = bamSel;
      if (seqDone) obs_done = k;
      if (seqErr) obs_err = k;
      if (seqDone || seqErr) begin
        obs_sel_last = bamSel; obs_ra1 = bamRA1; obs_ra2 = bamRA2;
        break;
      end
    end
    instValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ref_count = 0; ref_result = '0; ref_zero = 1'b0;
    #2;
    checks++;
    if (instReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instReady); end
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", out_vec()); end
    for (int i = 0; i < 32; i++) set_reg(5'(i), (i == 0) ? 32'd0 : $urandom);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    set_reg(5'd23, 32'd10); set_reg(5'd12, 32'd5);
    issue({6'b0, 5'd23, 5'd12, 5'd13, 5'd0, 6'b100000}, 1'b0);
    checks++;
    if (obs_done !== 2 + SETTLE) begin errors++; $display("FAIL add_latency: got %0d want %0d", obs_done, 2 + SETTLE); end
    checks++;
    if (obs_sel_first !== 4'b0010 || obs_sel_last !== 4'b0010) begin
      errors++; $display("FAIL add_sel: got %b/%b want 0010", obs_sel_first, obs_sel_last); end
    checks++;
    if (obs_rw !== 1 || obs_rw_addr !== 5'd13) begin
      errors++; $display("FAIL add_strobe: got %0d pulses addr %0d want 1 addr 13", obs_rw, obs_rw_addr); end
    checks++;
    if (seqResult !== 32'd15 || seqZero !== 1'b0 || seqCount !== 16'd1) begin
      errors++; $display("FAIL add_result: got %0d z%b c%0d want 15 z0 c1", seqResult, seqZero, seqCount); end
  endtask

  task automatic test_sub();
    set_reg(5'd15, 32'd42); set_reg(5'd7, 32'd42);
    issue({6'b0, 5'd15, 5'd7, 5'd14, 5'd0, 6'b100010}, 1'b0);
    checks++;
    if (obs_sel_last !== 4'b0110) begin errors++; $display("FAIL sub_sel: got %b want 0110", obs_sel_last); end
    checks++;
    if (seqResult !== 32'd0 || seqZero !== 1'b1 || bank[14] !== 32'd0) begin
      errors++; $display("FAIL sub_result: got %0d z%b r14=%0d want 0 z1 r14=0", seqResult, seqZero, bank[14]); end
  endtask

  task automatic test_memw();
    issue({6'b101011, 5'd3, 5'd5, 16'd456}, 1'b0);
    checks++;
    if (obs_done !== 2) begin errors++; $display("FAIL memw_latency: got %0d want 2", obs_done); end
    checks++;
    if (obs_wr !== 1 || obs_wr_addr !== 5'd5 || obs_wr_data !== 32'd456 || obs_rw !== 0) begin
      errors++; $display("FAIL memw_strobe: got wr%0d a%0d d%0d rw%0d want wr1 a5 d456 rw0",
                         obs_wr, obs_wr_addr, obs_wr_data, obs_rw); end
    checks++;
    if (seqResult !== 32'd456 || seqZero !== ref_zero || bank[5] !== 32'd456) begin
      errors++; $display("FAIL memw_result: got %0d z%b r5=%0d want 456 z%b r5=456",
                         seqResult, seqZero, bank[5], ref_zero); end
  endtask

  task automatic test_illegal();
    issue({6'b0, 5'd1, 5'd7, 5'd1, 5'd0, 6'b000111}, 1'b0);
    checks++;
    if (obs_err !== 2 || obs_done !== -1 || obs_rw !== 0 || obs_wr !== 0) begin
      errors++; $display("FAIL illegal_err: got err%0d done%0d rw%0d wr%0d want err2 none",
                         obs_err, obs_done, obs_rw, obs_wr); end
    checks++;
    if (seqCount !== 16'(ref_count)) begin
      errors++; $display("FAIL illegal_count: got %0d want %0d", seqCount, ref_count); end
    issue({6'b0, 5'd1, 5'd7, 5'd1, 5'd0, 6'b100100}, 1'b0);
    checks++;
    if (obs_done !== 2 + SETTLE || seqCount !== 16'(ref_count) || seqResult !== ref_result) begin
      errors++; $display("FAIL and_after_err: got lat%0d c%0d r%h want lat%0d c%0d r%h",
                         obs_done, seqCount, seqResult, 2 + SETTLE, ref_count, ref_result); end
  endtask

  task automatic test_rd0();
    logic [31:0] r0_before;
    r0_before = bank[0];
    issue({6'b0, 5'd23, 5'd12, 5'd0, 5'd0, 6'b100000}, 1'b1);
    checks++;
    if (obs_rw !== 0 || obs_done !== 2 + SETTLE || bank[0] !== r0_before) begin
      errors++; $display("FAIL rd0_protect: got rw%0d lat%0d r0=%h want rw0 lat%0d r0=%h",
                         obs_rw, obs_done, bank[0], 2 + SETTLE, r0_before); end
    checks++;
    if (obs_ready_busy !== 0) begin errors++; $display("FAIL busy_ready: got %0d want 0", obs_ready_busy); end
    repeat (8) @(negedge clk);
    checks++;
    if (seqCount !== 16'(ref_count) || seqResult !== ref_result) begin
      errors++; $display("FAIL rd0_single_accept: got c%0d r%h want c%0d r%h",
                         seqCount, seqResult, ref_count, ref_result); end
  endtask

  task automatic test_random();
    int exp_done, exp_err, exp_rw, exp_wr, bad;
    for (int n = 0; n < 60; n++) begin
      issue(gen_inst(), n[0]);
      exp_done = (cur_kind == 0) ? 2 + SETTLE : (cur_kind == 1) ? 2 : -1;
      exp_err  = (cur_kind == 2) ? 2 : -1;
      exp_rw   = (cur_kind == 0 && cur_rd != 5'd0) ? 1 : 0;
      exp_wr   = (cur_kind == 1) ? 1 : 0;
      checks++;
      if (obs_done !== exp_done || obs_err !== exp_err) begin
        errors++; $display("FAIL rand_timing[%0d]: got d%0d e%0d want d%0d e%0d",
                           n, obs_done, obs_err, exp_done, exp_err); end
      checks++;
      if (obs_rw !== exp_rw || obs_wr !== exp_wr || obs_both !== 0) begin
        errors++; $display("FAIL rand_strobes[%0d]: got rw%0d wr%0d both%0d want rw%0d wr%0d both0",
                           n, obs_rw, obs_wr, obs_both, exp_rw, exp_wr); end
      checks++;
      if (seqResult !== ref_result || seqZero !== ref_zero || seqCount !== 16'(ref_count) ||
          w2_seqCount !== 2'(ref_count)) begin
        errors++; $display("FAIL rand_status[%0d]: got r%h z%b c%0d c2=%0d want r%h z%b c%0d",
                           n, seqResult, seqZero, seqCount, w2_seqCount, ref_result, ref_zero,
                           ref_count); end
      if (cur_kind == 0) begin
        checks++;
        if (obs_sel_first !== cur_sel || obs_sel_last !== cur_sel) begin
          errors++; $display("FAIL rand_sel[%0d]: got %b/%b want %b", n, obs_sel_first,
                             obs_sel_last, cur_sel); end
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (bank[i] !== ref_bank[i]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rand_bank: got %0d differing regs want 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] old9;
    set_reg(5'd2, 32'd100); set_reg(5'd3, 32'd23);
    old9 = bank[9];
    start({6'b0, 5'd2, 5'd3, 5'd9, 5'd0, 6'b100000}, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bamSel !== 4'b0010) begin errors++; $display("FAIL mid_exec_sel: got %b want 0010", bamSel); end
    rst_n = 1'b0; #1;
    checks++;
    if (out_vec() !== '0 || instReady !== 1'b1) begin
      errors++; $display("FAIL mid_exec_reset: got %h rdy%b want 0 rdy1", out_vec(), instReady); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    ref_count = 0; ref_result = '0; ref_zero = 1'b0;
    start({6'b0, 5'd2, 5'd3, 5'd9, 5'd0, 6'b100000}, 1'b0);
    repeat (2 + SETTLE) @(negedge clk);
    checks++;
    if (bamRegWrite !== 1'b1) begin errors++; $display("FAIL wb_strobe: got %b want 1", bamRegWrite); end
    rst_n = 1'b0; #1;
    checks++;
    if (bamRegWrite !== 1'b0 || seqDone !== 1'b0) begin
      errors++; $display("FAIL wb_reset_drop: got rw%b done%b want 0 0", bamRegWrite, seqDone); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    checks++;
    if (bank[9] !== old9 || seqCount !== 16'd0) begin
      errors++; $display("FAIL reset_no_write: got r9=%h c%0d want r9=%h c0", bank[9], seqCount, old9); end
  endtask

  task automatic test_count_wrap();
    for (int n = 0; n < 5; n++) issue({6'b101011, 5'd0, 5'(n + 20), 16'($urandom)}, 1'b0);
    checks++;
    if (w2_seqCount !== 2'd1 || seqCount !== 16'd5) begin
      errors++; $display("FAIL count_wrap: got %0d/%0d want 1/5", w2_seqCount, seqCount); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_memw();
    test_illegal();
    test_rd0();
    test_random();
    test_reset_mid();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
